// File: rtl/noc_pkg.sv
// Shared definitions for the mesh load scheduler: packet layout, packet types,
// mesh geometry and the PE / row-adder coordinate helpers.
package noc_pkg;

  localparam int PKT_W     = 39;
  localparam int PAYLOAD_W = 21;
  localparam int DEST_LSB  = 31;
  localparam int SRC_LSB   = 23;
  localparam int TYPE_LSB  = 21;

  localparam int PE_COUNT = 9;
  localparam int ROWS     = 3;
  localparam logic [3:0] RADD_Y = 4'd4;

  typedef enum logic [1:0] {
    PKT_FILTER = 2'b00,
    PKT_IFMAP  = 2'b01,
    PKT_RESULT = 2'b10,
    PKT_RSVD   = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic [7:0]           dest;
    logic [7:0]           src;
    pkt_type_e            ptype;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILT,
    S_LOAD_IFMAP,
    S_WAIT_RES,
    S_DONE
  } state_e;

  // PEs fill a 3x3 block: x = k/3, y = k%3 + 1 (column 0 is the scheduler's).
  function automatic logic [7:0] pe_addr(input logic [3:0] k);
    logic [3:0] x;
    logic [3:0] y;
    x = k / 4'd3;
    y = (k % 4'd3) + 4'd1;
    return {x, y};
  endfunction

  function automatic logic [7:0] radd_addr(input logic [1:0] r);
    return {2'b00, r, RADD_Y};
  endfunction

endpackage

// File: rtl/noc_pkt_fetch.sv
// Scratchpad read strobe plus output packet register with valid/ready stall.
// At most one read is outstanding; a stalled packet is frozen until accepted.
module noc_pkt_fetch
  import noc_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_more,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [7:0]           i_dest,
  input  pkt_type_e            i_type,
  output logic                 o_mem_rd_en,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic [PAYLOAD_W-1:0] i_mem_rdata,
  output logic                 o_pkt_valid,
  input  logic                 i_pkt_ready,
  output logic [PKT_W-1:0]     o_pkt_data
);

  logic      r_pend;
  logic      r_held;
  pkt_t      r_pkt;
  logic [7:0] r_dest;
  pkt_type_e r_type;
  pkt_t      w_live;

  assign o_pkt_valid = r_pend | r_held;
  assign o_mem_rd_en = i_more && (!o_pkt_valid || i_pkt_ready);
  assign o_mem_addr  = o_mem_rd_en ? i_addr : '0;

  // Read data is only on the bus the cycle after the strobe; later cycles use r_pkt.
  always_comb begin
    w_live = '0;
    if (r_pend) begin
      w_live.dest    = r_dest;
      w_live.src     = 8'h00;
      w_live.ptype   = r_type;
      w_live.payload = i_mem_rdata;
    end
  end

  assign o_pkt_data = r_held ? r_pkt : w_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_held <= 1'b0;
      r_pkt  <= '0;
      r_dest <= '0;
      r_type <= PKT_FILTER;
    end else begin
      r_pend <= o_mem_rd_en;
      if (o_mem_rd_en) begin
        r_dest <= i_dest;
        r_type <= i_type;
      end
      if (r_pend && !i_pkt_ready) begin
        r_held <= 1'b1;
        r_pkt  <= w_live;
      end else if (i_pkt_ready) begin
        r_held <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/noc_load_scheduler.sv
// Sequences one convolution run from mesh node (0,0): filters to all PEs, then per
// timestep one ifmap per PE followed by collecting one result from each row adder.
module noc_load_scheduler
  import noc_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int TS_W       = 8,
  parameter int IFMAP_BASE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TS_W-1:0]      num_timesteps,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PAYLOAD_W-1:0] mem_rdata,
  output logic                 pkt_out_valid,
  input  logic                 pkt_out_ready,
  output logic [PKT_W-1:0]     pkt_out_data,
  input  logic                 pkt_in_valid,
  output logic                 pkt_in_ready,
  input  logic [PKT_W-1:0]     pkt_in_data,
  output logic                 res_valid,
  output logic [1:0]           res_row,
  output logic [TS_W-1:0]      res_ts,
  output logic [PAYLOAD_W-1:0] res_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               r_state;
  state_e               w_next;
  logic [3:0]           r_k;
  logic [TS_W-1:0]      r_t;
  logic [TS_W-1:0]      r_nts;
  logic [ROWS-1:0]      r_rowmask;
  logic                 r_err;
  logic                 r_res_valid;
  logic [1:0]           r_res_row;
  logic [TS_W-1:0]      r_res_ts;
  logic [PAYLOAD_W-1:0] r_res_data;

  logic                 w_loading;
  logic                 w_more;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_start_ok;
  logic [ADDR_W-1:0]    w_addr;
  logic [ADDR_W-1:0]    w_ifaddr;
  pkt_type_e            w_out_type;
  logic                 w_acc;
  logic [3:0]           w_src_x;
  pkt_type_e            w_in_type;
  logic [ROWS-1:0]      w_rowbit;
  logic                 w_good;
  logic                 w_bad;
  logic                 w_allrows;
  logic                 w_final;
  logic                 w_unused;

  assign w_loading  = (r_state == S_LOAD_FILT) || (r_state == S_LOAD_IFMAP);
  assign w_more     = w_loading && (r_k < 4'(PE_COUNT));
  assign w_hs       = pkt_out_valid && pkt_out_ready;
  assign w_last     = w_hs && (r_k == 4'(PE_COUNT));
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_ifaddr   = ADDR_W'(IFMAP_BASE) + ADDR_W'(r_t) * ADDR_W'(PE_COUNT) + ADDR_W'(r_k);
  assign w_addr     = (r_state == S_LOAD_FILT) ? ADDR_W'(r_k) : w_ifaddr;
  assign w_out_type = (r_state == S_LOAD_FILT) ? PKT_FILTER : PKT_IFMAP;

  noc_pkt_fetch #(.ADDR_W(ADDR_W)) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_more      (w_more),
    .i_addr      (w_addr),
    .i_dest      (pe_addr(r_k)),
    .i_type      (w_out_type),
    .o_mem_rd_en (mem_rd_en),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_pkt_valid (pkt_out_valid),
    .i_pkt_ready (pkt_out_ready),
    .o_pkt_data  (pkt_out_data)
  );

  assign pkt_in_ready = (r_state == S_WAIT_RES);
  assign w_acc        = pkt_in_valid && pkt_in_ready;
  assign w_src_x      = pkt_in_data[SRC_LSB+4 +: 4];
  assign w_in_type    = pkt_type_e'(pkt_in_data[TYPE_LSB +: 2]);
  assign w_unused     = ^{pkt_in_data[DEST_LSB +: 8], pkt_in_data[SRC_LSB +: 4]};

  // Only x = 0..2 names a real row adder; anything else leaves w_rowbit empty.
  always_comb begin
    w_rowbit = '0;
    case (w_src_x)
      4'd0:    w_rowbit = 3'b001;
      4'd1:    w_rowbit = 3'b010;
      4'd2:    w_rowbit = 3'b100;
      default: w_rowbit = '0;
    endcase
  end

  assign w_good    = w_acc && (w_in_type == PKT_RESULT) && (w_rowbit != '0)
                     && ((r_rowmask & w_rowbit) == '0);
  assign w_bad     = w_acc && !w_good;
  assign w_allrows = w_good && ((r_rowmask | w_rowbit) == '1);
  assign w_final   = w_allrows && (r_t == (r_nts - TS_W'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = (num_timesteps == '0) ? S_DONE : S_LOAD_FILT;
      S_LOAD_FILT:  if (w_last) w_next = S_LOAD_IFMAP;
      S_LOAD_IFMAP: if (w_last) w_next = S_WAIT_RES;
      S_WAIT_RES:   if (w_allrows) w_next = w_final ? S_DONE : S_LOAD_IFMAP;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_t         <= '0;
      r_nts       <= '0;
      r_rowmask   <= '0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_ts    <= '0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok || w_last || w_allrows) begin
        r_k <= '0;
      end else if (mem_rd_en) begin
        r_k <= r_k + 4'd1;
      end
      if (w_start_ok) begin
        r_t   <= '0;
        r_nts <= num_timesteps;
      end else if (w_allrows && !w_final) begin
        r_t <= r_t + TS_W'(1);
      end
      if (r_state != S_WAIT_RES) begin
        r_rowmask <= '0;
      end else if (w_good) begin
        r_rowmask <= r_rowmask | w_rowbit;
      end
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (w_bad) begin
        r_err <= 1'b1;
      end
      r_res_valid <= w_good;
      if (w_good) begin
        r_res_row  <= w_src_x[1:0];
        r_res_ts   <= r_t;
        r_res_data <= pkt_in_data[0 +: PAYLOAD_W];
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_row   = r_res_row;
  assign res_ts    = r_res_ts;
  assign res_data  = r_res_data;
  assign err       = r_err;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: doc/noc_load_scheduler.md
# noc_load_scheduler

- Clocked controller that sequences one convolution run on the 3x5 mesh.
- Injects one filter packet into each of the 9 PEs, then, per timestep, one ifmap packet into each PE.
- Waits for the 3 row-adder result packets before starting the next timestep.
- Sits at mesh node (0,0): drives that router's local input and consumes its local output. Also reads operands from a word-addressed scratchpad.

## Interface
- ADDR_W, 12: scratchpad address width.
- TS_W, 8: timestep counter width.
- IFMAP_BASE, 16: first ifmap word address. Filters occupy addresses 0..8.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run. Ignored while busy.
- num_timesteps  in  TS_W  timesteps for the run. Sampled on start.
- mem_rd_en  out  1  scratchpad read strobe. Data arrives 1 cycle later.
- mem_addr  out  ADDR_W  scratchpad read address.
- mem_rdata  in  21  read data.
- pkt_out_valid  out  1  packet to router (0,0) local_in.
- pkt_out_ready  in  1  router accepts.
- pkt_out_data  out  39  packet.
- pkt_in_valid  in  1  packet from router (0,0) local_out.
- pkt_in_ready  out  1  scheduler accepts.
- pkt_in_data  in  39  packet.
- res_valid  out  1  one-cycle pulse per accepted result.
- res_row  out  2  result row, 0..2.
- res_ts  out  TS_W  timestep the result belongs to.
- res_data  out  21  result payload.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky protocol error. Cleared only by reset or start.

## Operation
- Packet format, 39 bits:
  - [38:31] dest {x[3:0], y[3:0]}
  - [30:23] src, always 8'h00 on output
  - [22:21] type: 00 filter, 01 ifmap, 10 result, 11 reserved
  - [20:0] payload
- PE k (0..8) lives at x = k/3, y = k%3 + 1. Row adder r lives at x = r, y = 4. A result's row is src x.
- States:
  - IDLE: busy=0.
  - start with num_timesteps==0 → done pulse, stay IDLE, no packets.
  - start otherwise → LOAD_FILT, with k=0 and t=0.
- LOAD_FILT: for k = 0..8, read address k and send a filter packet to PE k. After the handshake for k=8 → LOAD_IFMAP.
- LOAD_IFMAP: for k = 0..8, read address IFMAP_BASE + 9*t + k (modulo 2^ADDR_W) and send an ifmap packet to PE k. After k=8 → WAIT_RES with rowmask cleared.
- WAIT_RES:
  - pkt_in_ready=1. Each accepted result of type 10 with row r not set in rowmask sets bit r and pulses res_* with res_ts=t.
  - A duplicate row, row 3 (src x=3), or non-result type is consumed without a res pulse and sets err.
  - When rowmask==3'b111:
    - if t == num_timesteps-1 → DONE;
    - else t increments, k=0 → LOAD_IFMAP.
- DONE: done=1 for one cycle → IDLE.
- pkt_in_ready=0 in every state except WAIT_RES. Results never arrive earlier, because row adders need the timestep's ifmaps.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; k, t, rowmask 0; output register empty.
  - Reset mid-run abandons in-flight packets, with no flush.
- Fetch pipeline:
  - mem_rd_en is issued in a cycle where the output register is empty, or is being emptied by a handshake (valid & ready), and packets remain in the phase.
  - pkt_out_valid rises the cycle after mem_rd_en, with mem_rdata in the payload.
  - Valid and data hold stable until ready.
  - Throughput is 1 packet/cycle when ready stays high. First packet valid 2 cycles after start.
- No read is issued while a valid packet is stalled (ready=0), so at most one read is outstanding.
- Result path: res_valid is registered and rises the cycle after the pkt_in handshake.
- Done timing: done follows 1 cycle after the accept that completes the final rowmask. busy drops in the same cycle as done.
- start coincident with done is ignored.

## Structure
- Shared package noc_pkg holds:
  - packet field positions and the packed struct;
  - the type enum;
  - PE_COUNT=9 and ROWS=3;
  - function pe_addr(k) returning {x,y}, and the row-adder coordinates.
- Sub-module noc_pkt_fetch holds the read strobe, output register and valid/ready stall logic. The scheduler FSM drives its address, header and "more" inputs.

## Test plan
- **Single timestep.** Reset; start with num_timesteps=1, memory word = address, ready=1.
  - 9 filter packets to dest 01,02,03,11,12,13,21,22,23 with payloads 0..8, on consecutive cycles.
  - Then 9 ifmap packets with payloads 16..24.
  - Inject results from src 00,10,20 → three res pulses (rows 0,1,2, ts=0), then done.
- **Backpressure.** Toggle pkt_out_ready at random. No packet is dropped or duplicated, data is stable while stalled, and mem_rd_en stays 0 during a stall.
- **Three timesteps.** num_timesteps=3 → ifmap payload bases 16, 25, 34. Results are returned out of row order (2,0,1); res_ts increments 0,1,2; exactly one done.
- **Errors.**
  - A duplicate row-1 result in a timestep → err=1, a single res pulse for row 1, and the run still completes after row 0 and row 2.
  - A type-01 packet in WAIT_RES → err.
- **Zero / start while busy.**
  - num_timesteps=0 → done 1 cycle after start, with no mem_rd_en and no packets.
  - start during LOAD_IFMAP → ignored.
- **Reset mid-run.** rst_n=0 for 1 cycle during LOAD_IFMAP (k=4) → all outputs 0 next cycle. A fresh start replays from filter k=0.
